// File: rtl/ram_pkg.sv
// Shared types and defaults for the parametrised sweep-fill word RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/ram_nxw_sweep_if.sv
// Access and sweep-control bundle between the loader/datapath and the RAM.
interface ram_nxw_sweep_if #(
  parameter int WIDTH = ram_pkg::DEF_WIDTH,
  parameter int DEPTH = ram_pkg::DEF_DEPTH
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic              en;
  logic              r_w;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  in;
  logic              init;
  logic [WIDTH-1:0]  fill;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport master (
    output en, r_w, addr, in, init, fill,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  en, r_w, addr, in, init, fill,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/ram_sweep_ctrl.sv
// Fill-sweep engine: captures the pattern on init and walks every word once,
// raising busy for the whole walk and pulsing done after the last write.
module ram_sweep_ctrl import ram_pkg::*; #(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              init,
  input  logic [WIDTH-1:0]  fill,
  output logic              acc_ok,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic [WIDTH-1:0]  sweep_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sweep_state_t      state_r, state_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0]  fill_r, fill_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;

  // State, counter, captured pattern and status flags.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      fill_r  <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      fill_r  <= fill_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; done is a single-cycle pulse so it defaults low.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    fill_s  = fill_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (init) begin
          state_s = SWEEP;
          cnt_s   = {ADDR_W{1'b0}};
          fill_s  = fill;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      SWEEP: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = IDLE;
          cnt_s   = {ADDR_W{1'b0}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s   = cnt_r + ADDR_W'(1);
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {ADDR_W{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // An init in IDLE wins over any access in the same cycle.
  assign acc_ok     = (state_r == IDLE) && !init;
  assign sweep_we   = (state_r == SWEEP);
  assign sweep_addr = cnt_r;
  assign sweep_data = fill_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: rtl/ram_nxw_sweep.sv
// DEPTH x WIDTH single-port RAM with registered read, read-valid strobe,
// asynchronous array clear and a built-in fill sweep.
module ram_nxw_sweep import ram_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic           clk,
  input logic           clear_n,
  ram_nxw_sweep_if.slave bus
);

  localparam int                ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [WIDTH-1:0]  out_r;
  logic              out_valid_r;
  logic              acc_ok_s;
  logic              sweep_we_s;
  logic [ADDR_W-1:0] sweep_addr_s;
  logic [WIDTH-1:0]  sweep_data_s;
  logic              in_range_s;
  logic              wr_s;
  logic              rd_s;
  logic [WIDTH-1:0]  rd_data_s;

  ram_sweep_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (clk),
    .clear_n    (clear_n),
    .init       (bus.init),
    .fill       (bus.fill),
    .acc_ok     (acc_ok_s),
    .sweep_we   (sweep_we_s),
    .sweep_addr (sweep_addr_s),
    .sweep_data (sweep_data_s),
    .busy       (bus.busy),
    .done       (bus.done)
  );

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign in_range_s = ({1'b0, bus.addr} < DEPTH_L);
  assign wr_s       = acc_ok_s && bus.en && bus.r_w && in_range_s;
  assign rd_s       = acc_ok_s && bus.en && !bus.r_w;
  assign rd_data_s  = in_range_s ? mem_r[bus.addr] : {WIDTH{1'b0}};

  // Word array: cleared by reset, written by the sweep or a CPU write.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sweep_we_s && (sweep_addr_s == ADDR_W'(i))) begin
          mem_r[i] <= sweep_data_s;
        end else if (wr_s && (bus.addr == ADDR_W'(i))) begin
          mem_r[i] <= bus.in;
        end
      end
    end
  end

  // Read register; out holds its value when no read is accepted.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      out_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (rd_s) begin
      out_r       <= rd_data_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

endmodule
